// File: rtl/unidade_controle.sv
// Multi-cycle control unit: sequences FETCH/DECODE/EXEC/MEM/WB and drives the datapath control bus.
// Optional feature macro: ILLEGAL_TRAP_EN (illegal decode locks the unit in TRAP until reset).
module unidade_controle #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run,
   input  logic [31:0]      instrucao,
   output logic             load_en,
   output logic             store_en,
   output logic [1:0]       op_ula,
   output logic             operation_type,
   output logic             ula_entry,
   output logic             branch,
   output logic             sign,
   output logic             pc_write,
   output logic             busy,
   output logic             illegal,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] retired
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_DECODE = 3'd2;
   localparam logic [2:0] S_EXEC   = 3'd3;
   localparam logic [2:0] S_MEM    = 3'd4;
   localparam logic [2:0] S_WB     = 3'd5;
   localparam logic [2:0] S_TRAP   = 3'd7;

   localparam logic [2:0] K_ALU = 3'd0;
   localparam logic [2:0] K_LD  = 3'd1;
   localparam logic [2:0] K_SD  = 3'd2;
   localparam logic [2:0] K_BR  = 3'd3;
   localparam logic [2:0] K_ILL = 3'd4;

   logic [2:0]       state_q, state_d;
   logic [31:0]      ir_q, ir_d;
   logic [2:0]       kind_q, kind_d;
   logic [1:0]       op_ula_q, op_ula_d;
   logic             op_type_q, op_type_d;
   logic             ula_entry_q, ula_entry_d;
   logic             branch_q, branch_d;
   logic             sign_q, sign_d;
   logic [CNT_W-1:0] retired_q, retired_d;

   logic [2:0] dec_kind;
   logic [1:0] dec_op_ula;
   logic       dec_op_type, dec_ula_entry, dec_branch, dec_sign;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       pc_write_c, last_c;

   assign opcode = ir_q[6:0];
   assign funct3 = ir_q[14:12];
   assign funct7 = ir_q[31:25];

   // Unsupported encodings fall through with all fields zero and kind K_ILL.
   always_comb begin
      dec_kind      = K_ILL;
      dec_op_ula    = 2'b00;
      dec_op_type   = 1'b0;
      dec_ula_entry = 1'b0;
      dec_branch    = 1'b0;
      dec_sign      = 1'b0;
      case (opcode)
         7'b0110011: begin
            if (funct3 == 3'b000 && (funct7 == 7'b0000000 || funct7 == 7'b0100000)) begin
               dec_kind      = K_ALU;
               dec_op_ula    = (funct7 == 7'b0000000) ? 2'b01 : 2'b00;
               dec_op_type   = 1'b1;
               dec_ula_entry = 1'b1;
            end
         end
         7'b0010011: begin
            if (funct3 == 3'b000 || funct3 == 3'b001) begin
               dec_kind    = K_ALU;
               dec_op_ula  = (funct3 == 3'b000) ? 2'b01 : 2'b00;
               dec_op_type = 1'b1;
            end
         end
         7'b0000011: begin
            if (funct3 == 3'b011) begin
               dec_kind   = K_LD;
               dec_op_ula = 2'b01;
            end
         end
         7'b0100011: begin
            if (funct3 == 3'b011) begin
               dec_kind   = K_SD;
               dec_op_ula = 2'b01;
            end
         end
         7'b1100011: begin
            if (funct3 != 3'b010 && funct3 != 3'b011) begin
               dec_kind      = K_BR;
               dec_op_ula    = (funct3[2] == 1'b0) ? 2'b10 : 2'b11;
               dec_op_type   = 1'b1;
               dec_ula_entry = 1'b1;
               dec_branch    = 1'b1;
               dec_sign      = (funct3[2:1] != 2'b11);
            end
         end
         default: ;
      endcase
   end

   // The cycle carrying pc_write is always the final state of an instruction.
   always_comb begin
      pc_write_c = 1'b0;
      case (state_q)
         S_EXEC:  pc_write_c = (kind_q == K_BR) || (kind_q == K_ILL);
         S_MEM:   pc_write_c = (kind_q == K_SD);
         S_WB:    pc_write_c = 1'b1;
         default: pc_write_c = 1'b0;
      endcase
   end
   assign last_c = pc_write_c;

   always_comb begin
      state_d     = state_q;
      ir_d        = ir_q;
      kind_d      = kind_q;
      op_ula_d    = op_ula_q;
      op_type_d   = op_type_q;
      ula_entry_d = ula_entry_q;
      branch_d    = branch_q;
      sign_d      = sign_q;
      retired_d   = retired_q;
      case (state_q)
         S_IDLE:  if (run) state_d = S_FETCH;
         S_FETCH: begin
            ir_d    = instrucao;
            state_d = S_DECODE;
         end
         S_DECODE: begin
            kind_d      = dec_kind;
            op_ula_d    = dec_op_ula;
            op_type_d   = dec_op_type;
            ula_entry_d = dec_ula_entry;
            branch_d    = dec_branch;
            sign_d      = dec_sign;
`ifdef ILLEGAL_TRAP_EN
            state_d     = (dec_kind == K_ILL) ? S_TRAP : S_EXEC;
`else
            state_d     = S_EXEC;
`endif
         end
         S_EXEC:  if (kind_q == K_ALU) state_d = S_WB;
                  else if (kind_q == K_LD || kind_q == K_SD) state_d = S_MEM;
         S_MEM:   if (kind_q == K_LD) state_d = S_WB;
         S_WB:    ;
         S_TRAP:  state_d = S_TRAP;
         default: state_d = S_IDLE;
      endcase
      if (last_c) begin
         state_d = run ? S_FETCH : S_IDLE;
         if (kind_q != K_ILL) retired_d = retired_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         ir_q        <= '0;
         kind_q      <= K_ALU;
         op_ula_q    <= 2'b00;
         op_type_q   <= 1'b0;
         ula_entry_q <= 1'b0;
         branch_q    <= 1'b0;
         sign_q      <= 1'b0;
         retired_q   <= '0;
      end else begin
         state_q     <= state_d;
         ir_q        <= ir_d;
         kind_q      <= kind_d;
         op_ula_q    <= op_ula_d;
         op_type_q   <= op_type_d;
         ula_entry_q <= ula_entry_d;
         branch_q    <= branch_d;
         sign_q      <= sign_d;
         retired_q   <= retired_d;
      end
   end

   assign load_en        = (state_q == S_WB);
   assign store_en       = (state_q == S_MEM) && (kind_q == K_SD);
   assign pc_write       = pc_write_c;
   assign busy           = (state_q >= S_FETCH) && (state_q <= S_WB);
   assign op_ula         = op_ula_q;
   assign operation_type = op_type_q;
   assign ula_entry      = ula_entry_q;
   assign branch         = branch_q;
   assign sign           = sign_q;
   assign state          = state_q;
   assign retired        = retired_q;
`ifdef ILLEGAL_TRAP_EN
   assign illegal        = (state_q == S_TRAP);
`else
   assign illegal        = (state_q == S_EXEC) && (kind_q == K_ILL);
`endif

endmodule

// File: tb/tb_unidade_controle.sv
// Directed bench for unidade_controle: vector table per instruction class plus hand-written
// sequences for back-to-back issue, run drop, illegal opcode and reset mid-instruction.
module tb_unidade_controle;

   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             run = 1'b0;
   logic [31:0]      instrucao = '0;
   logic             load_en, store_en, operation_type, ula_entry, branch, sign;
   logic             pc_write, busy, illegal;
   logic [1:0]       op_ula;
   logic [2:0]       state;
   logic [CNT_W-1:0] retired;

   int total = 0;
   int bad = 0;
   int exp_retired = 0;
   logic [2:0] exp_q[$];

   typedef struct {
      string       name;
      logic [31:0] instr;
      int          len;
      logic [14:0] seq;      // state i lives in seq[3*i +: 3]
      logic        st;
      logic [1:0]  op_ula;
      logic        op_type;
      logic        ula_entry;
      logic        br;
      logic        sgn;
   } vec_t;

   vec_t vecs[11];

   unidade_controle #(.CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .run(run), .instrucao(instrucao),
      .load_en(load_en), .store_en(store_en), .op_ula(op_ula),
      .operation_type(operation_type), .ula_entry(ula_entry), .branch(branch),
      .sign(sign), .pc_write(pc_write), .busy(busy), .illegal(illegal),
      .state(state), .retired(retired)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input vec_t v);
      logic [2:0] es;
      for (int i = 0; i < v.len; i++) exp_q.push_back(v.seq[3*i +: 3]);
      @(negedge clk);
      instrucao = v.instr;
      run = 1'b1;
      tick();
      for (int i = 0; i < v.len; i++) begin
         es = exp_q.pop_front();
         if (i == 0) run = 1'b0;
         chk({v.name, " state"}, state, es);
         chk({v.name, " load_en"}, load_en, es == 3'd5);
         chk({v.name, " store_en"}, store_en, v.st && es == 3'd4);
         chk({v.name, " pc_write"}, pc_write, i == v.len - 1);
         chk({v.name, " busy"}, busy, 1);
         if (i >= 2) begin
            chk({v.name, " op_ula"}, op_ula, v.op_ula);
            chk({v.name, " operation_type"}, operation_type, v.op_type);
            chk({v.name, " ula_entry"}, ula_entry, v.ula_entry);
            chk({v.name, " branch"}, branch, v.br);
            chk({v.name, " sign"}, sign, v.sgn);
         end
         tick();
      end
      exp_retired++;
      chk({v.name, " end state"}, state, 0);
      chk({v.name, " end busy"}, busy, 0);
      chk({v.name, " retired"}, retired, exp_retired);
   endtask

   initial begin
      vecs[0]  = '{"add",  32'h01538FB3, 4, {3'd0, 3'd5, 3'd3, 3'd2, 3'd1}, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[1]  = '{"sub",  32'h40000033, 4, {3'd0, 3'd5, 3'd3, 3'd2, 3'd1}, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[2]  = '{"addi", 32'h00500093, 4, {3'd0, 3'd5, 3'd3, 3'd2, 3'd1}, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{"subi", 32'h00501093, 4, {3'd0, 3'd5, 3'd3, 3'd2, 3'd1}, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[4]  = '{"ld",   32'h00703083, 5, {3'd5, 3'd4, 3'd3, 3'd2, 3'd1}, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[5]  = '{"sd",   32'h03DE3423, 4, {3'd0, 3'd4, 3'd3, 3'd2, 3'd1}, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[6]  = '{"beq",  32'h00000063, 3, {3'd0, 3'd0, 3'd3, 3'd2, 3'd1}, 1'b0, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1};
      vecs[7]  = '{"bne",  32'h00001063, 3, {3'd0, 3'd0, 3'd3, 3'd2, 3'd1}, 1'b0, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1};
      vecs[8]  = '{"blt",  32'h00004063, 3, {3'd0, 3'd0, 3'd3, 3'd2, 3'd1}, 1'b0, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1};
      vecs[9]  = '{"bltu", 32'h00006063, 3, {3'd0, 3'd0, 3'd3, 3'd2, 3'd1}, 1'b0, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[10] = '{"bgeu", 32'h00007063, 3, {3'd0, 3'd0, 3'd3, 3'd2, 3'd1}, 1'b0, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst state", state, 0);
      chk("rst busy", busy, 0);
      chk("rst retired", retired, 0);
      chk("rst op_ula", op_ula, 0);
      chk("rst enables", {load_en, store_en, pc_write, illegal}, 0);
      @(negedge clk);
      reset = 1'b1;
      tick();
      chk("idle without run", state, 0);

      foreach (vecs[k]) run_vec(vecs[k]);

      // Back-to-back: add with run held, then beq with run dropped
      @(negedge clk);
      instrucao = 32'h01538FB3;
      run = 1'b1;
      tick(); chk("b2b s0", state, 1);
      tick(); chk("b2b s1", state, 2);
      tick(); chk("b2b s2", state, 3);
      tick(); chk("b2b wb", state, 5); chk("b2b wb load_en", load_en, 1);
      instrucao = 32'h00000063;
      tick(); chk("b2b refetch", state, 1);
      run = 1'b0;
      tick(); chk("b2b decode", state, 2);
      tick(); chk("b2b exec", state, 3); chk("b2b branch", branch, 1);
      chk("b2b pc_write", pc_write, 1);
      tick(); chk("b2b idle", state, 0);
      exp_retired += 2;
      chk("b2b retired", retired, exp_retired);

      // run drops during EXEC of add: WB still completes
      @(negedge clk);
      instrucao = 32'h01538FB3;
      run = 1'b1;
      tick(); tick(); tick();
      chk("rundrop exec", state, 3);
      run = 1'b0;
      tick();
      chk("rundrop wb", state, 5);
      chk("rundrop wb load_en", load_en, 1);
      chk("rundrop wb pc_write", pc_write, 1);
      tick();
      chk("rundrop idle", state, 0);
      chk("rundrop busy", busy, 0);
      exp_retired++;
      chk("rundrop retired", retired, exp_retired);

      // Illegal opcode
      @(negedge clk);
      instrucao = 32'h0000007F;
      run = 1'b1;
      tick(); run = 1'b0;
      chk("ill fetch", state, 1);
      tick(); chk("ill decode", state, 2);
      tick();
`ifdef ILLEGAL_TRAP_EN
      for (int i = 0; i < 20; i++) begin
         chk("ill trap state", state, 7);
         chk("ill trap illegal", illegal, 1);
         chk("ill trap outs", {pc_write, load_en, store_en, busy}, 0);
         tick();
      end
      chk("ill retired", retired, exp_retired);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("ill reset state", state, 0);
      chk("ill reset illegal", illegal, 0);
      @(negedge clk);
      reset = 1'b1;
      exp_retired = 0;
`else
      chk("ill exec", state, 3);
      chk("ill illegal", illegal, 1);
      chk("ill pc_write", pc_write, 1);
      chk("ill enables", {load_en, store_en}, 0);
      tick();
      chk("ill idle", state, 0);
      chk("ill illegal cleared", illegal, 0);
      chk("ill retired", retired, exp_retired);
`endif

      // Reset during MEM of ld: no load_en pulse afterwards
      @(negedge clk);
      instrucao = 32'h00703083;
      run = 1'b1;
      tick(); run = 1'b0;
      tick(); tick(); tick();
      chk("ldrst mem", state, 4);
      #2 reset = 1'b0;
      #1;
      chk("ldrst state", state, 0);
      chk("ldrst outs", {load_en, store_en, pc_write, busy, op_ula}, 0);
      chk("ldrst retired", retired, 0);
      tick();
      chk("ldrst no load_en", load_en, 0);
      @(negedge clk);
      reset = 1'b1;
      tick();
      chk("ldrst idle", state, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
